i2c_slave_controller: RTL and testbench
=======================================

Name: i2c_slave_controller

Overview:
I2C target (slave) endpoint, the bus-side counterpart to i2c_master_controller. It oversamples SCL/SDA on i_clk, detects START, repeated START and STOP, and matches a fixed 7-bit address. It accepts write bytes toward the user side and serves read bytes from the user side. Standard-mode/fast-mode target for on-chip register blocks.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit bus address this target ACKs.
SYNC_STAGES, 2, synchronizer flops on SCL/SDA inputs (min 2).

Ports:
i_clk  input  1  system clock, must be ≥8x SCL frequency
i_reset  input  1  synchronous, active-high reset
io_scl  inout  1  I2C clock, open-drain; only driven when I2C_SLAVE_CLK_STRETCH_EN is defined, otherwise treated as input
io_sda  inout  1  I2C data, open-drain (drive 0 or Z only)
o_rx_data  output  8  last received write byte
o_rx_valid  output  1  1-cycle pulse, o_rx_data updated
i_tx_data  input  8  next read byte
o_tx_req  output  1  1-cycle pulse, i_tx_data must be valid by the next SCL falling edge
o_addr_match  output  1  1-cycle pulse on address match
o_rw  output  1  R/W bit of current transaction (1 = read)
o_busy  output  1  high from START to STOP
o_state  output  4  current FSM state
o_bit_count  output  4  bits shifted in current byte (0..8)

Behaviour:
- Reset: state IDLE, SDA/SCL released (Z), all outputs 0, shift register 0. Reset mid-transfer releases lines at the next i_clk edge; bus is ignored until the next START.
- Inputs pass through SYNC_STAGES flops plus one history flop. Edges are detected on synchronized values. Bus latency: 3 i_clk cycles.
- START = SDA fall while SCL high. STOP = SDA rise while SCL high. Both have priority over SCL-edge processing in the same cycle.
- START in any state: go to ADDR, bit_count=0, release SDA, o_busy=1. This also covers repeated START.
- STOP in any state: go to IDLE, release SDA, o_busy=0.
- Data is sampled on SCL rising edges. The SDA drive changes only on SCL falling edges. MSB first.
- State encoding: IDLE=0, ADDR=1, ADDR_ACK=2, WR_DATA=3, WR_ACK=4, RD_DATA=5, RD_ACK=6, WAIT_STOP=7.
- ADDR: shift in 8 bits. After the 8th rising edge, compare bits[7:1] with SLAVE_ADDR and latch o_rw=bit0.
  - Match: pulse o_addr_match; pulse o_tx_req if o_rw=1; at the next falling edge drive SDA low and go to ADDR_ACK.
  - No match: go to WAIT_STOP; SDA is never driven.
- ADDR_ACK: at the falling edge ending the ACK clock, release SDA.
  - o_rw=0: go to WR_DATA.
  - o_rw=1: load i_tx_data, drive bit7, go to RD_DATA.
- WR_DATA: after the 8th rising edge, update o_rx_data and pulse o_rx_valid. At the next falling edge drive ACK and go to WR_ACK. At the falling edge after that, release SDA and go to WR_DATA with bit_count=0.
- RD_DATA: drive bits 6..0 on successive falling edges. At the 8th falling edge release SDA and go to RD_ACK.
- RD_ACK: sample the master's ACK on the rising edge.
  - SDA=0: pulse o_tx_req; at the falling edge load i_tx_data, drive bit7, go to RD_DATA.
  - SDA=1 (NACK): go to WAIT_STOP with SDA released.
- WAIT_STOP: ignore everything except START or STOP.
- o_bit_count increments on each data-bit rising edge (ADDR/WR_DATA) or falling edge (RD_DATA). It clears on a byte boundary.
- SDA bit value 1 is always realised as Z; the block never drives high.

Optional Feature:
I2C_SLAVE_CLK_STRETCH_EN
- Defined:
  - Adds input i_tx_valid (1 bit).
  - At a falling edge where a read byte must be loaded and i_tx_valid=0, the block drives io_scl low.
  - It holds SCL low until the first i_clk cycle with i_tx_valid=1, then loads i_tx_data, drives bit7 and releases SCL one cycle later.
  - STOP/START/reset during the stretch release SCL immediately.
- Undefined: io_scl is never driven, i_tx_valid does not exist, and i_tx_data is sampled unconditionally at the load edge.

Test Plan:
- Write: START, 0xA0, 0x3C, STOP -> ACK driven on both 9th clocks; o_addr_match pulses once; o_rx_valid pulses once with o_rx_data=0x3C; o_busy 1→0; state returns to 0.
- Address miss: START, 0xA2, 0x55, STOP -> SDA never driven low; state 7 after the address byte; o_rx_valid never pulses; IDLE after STOP.
- Read: START, 0xA1; i_tx_data=0x5A then 0xC3; master ACKs the first byte and NACKs the second -> bus bits read 0x5A, 0xC3; o_tx_req pulses twice; state 7 after the NACK; SDA released.
- Repeated START: START, 0xA0, 0x11, Sr, 0xA1, read 0x77 with NACK, STOP -> o_rx_data=0x11, then 0x77 on the bus; o_rw 0→1; o_busy stays 1 across Sr.
- Reset mid-write: assert i_reset after 4 data bits of 0xF0 -> next cycle SDA/SCL=Z, all outputs 0, state 0; a following full write of 0x99 is received correctly.
- (STRETCH_EN) Read with i_tx_valid held low 20 cycles -> SCL held low ≥20 i_clk cycles after the ACK falling edge; the byte is delivered correctly after i_tx_valid=1; SCL is released one cycle after load.

Source files
------------

// File: rtl/i2c_slave_controller_if.sv
// User-side interface of the I2C target: receive/transmit data handshakes and status.
// The i_tx_valid handshake exists only when I2C_SLAVE_CLK_STRETCH_EN is defined.
interface i2c_slave_controller_if;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic [7:0] i_tx_data;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic       i_tx_valid;
`endif
  logic       o_tx_req;
  logic       o_addr_match;
  logic       o_rw;
  logic       o_busy;
  logic [3:0] o_state;
  logic [3:0] o_bit_count;

  modport slave (
    input  i_tx_data,
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    input  i_tx_valid,
`endif
    output o_rx_data, o_rx_valid, o_tx_req, o_addr_match,
    output o_rw, o_busy, o_state, o_bit_count
  );

  modport master (
    output i_tx_data,
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    output i_tx_valid,
`endif
    input  o_rx_data, o_rx_valid, o_tx_req, o_addr_match,
    input  o_rw, o_busy, o_state, o_bit_count
  );
endinterface

// File: rtl/i2c_slave_controller.sv
// I2C target endpoint: oversampled SCL/SDA, START/STOP detection, fixed 7-bit address,
// write bytes toward the user side, read bytes from it. Define I2C_SLAVE_CLK_STRETCH_EN for SCL stretching.
module i2c_slave_controller #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  inout  wire  io_scl,
  inout  wire  io_sda,
  i2c_slave_controller_if.slave usr
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    WR_DATA   = 4'd3,
    WR_ACK    = 4'd4,
    RD_DATA   = 4'd5,
    RD_ACK    = 4'd6,
    WAIT_STOP = 4'd7
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_hist, sda_hist;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;
  logic                   tx_ready;

  logic [6:0] shift_q;
  logic [3:0] bit_count;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, addr_match, rw, busy;

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic scl_oe, stretch;
  assign io_scl   = scl_oe ? 1'b0 : 1'bz;
  assign tx_ready = usr.i_tx_valid;
`else
  assign tx_ready = 1'b1;
`endif

  // Open drain: a '1' on the bus is always realised by releasing the line.
  assign io_sda = sda_oe ? 1'b0 : 1'bz;

  // Synchronizers reset to the idle-bus level so leaving reset never looks like a START.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      // NOTE: non-blocking so each stage captures the previous stage's old value.
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], io_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], io_sda};
      scl_hist <= scl_sync[SYNC_STAGES-1];
      sda_hist <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_hist;
  assign scl_fall  = ~scl_s &  scl_hist;
  assign start_det =  sda_hist & ~sda_s & scl_s & scl_hist;
  assign stop_det  = ~sda_hist &  sda_s & scl_s & scl_hist;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      shift_q    <= '0;
      bit_count  <= '0;
      sda_oe     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      tx_req     <= 1'b0;
      addr_match <= 1'b0;
      rw         <= 1'b0;
      busy       <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      scl_oe     <= 1'b0;
      stretch    <= 1'b0;
`endif
    end else begin
      rx_valid   <= 1'b0;
      tx_req     <= 1'b0;
      addr_match <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      // SCL stays low for the load cycle and is let go on the cycle after.
      if (scl_oe && !stretch) scl_oe <= 1'b0;
`endif
      if (start_det) begin
        state     <= ADDR;
        bit_count <= '0;
        sda_oe    <= 1'b0;
        busy      <= 1'b1;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        scl_oe    <= 1'b0;
        stretch   <= 1'b0;
`endif
      end else if (stop_det) begin
        state     <= IDLE;
        bit_count <= '0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        scl_oe    <= 1'b0;
        stretch   <= 1'b0;
      end else if (stretch) begin
        if (usr.i_tx_valid) begin
          stretch   <= 1'b0;
          shift_q   <= usr.i_tx_data[6:0];
          sda_oe    <= ~usr.i_tx_data[7];
          bit_count <= '0;
          state     <= RD_DATA;
        end
`endif
      end else begin
        case (state)
          IDLE: ;

          ADDR: begin
            if (scl_rise && bit_count < 4'd8) begin
              shift_q   <= {shift_q[5:0], sda_s};
              bit_count <= bit_count + 4'd1;
              if (bit_count == 4'd7) begin
                rw <= sda_s;
                // shift_q still holds the seven address bits before the R/W bit.
                if (shift_q == SLAVE_ADDR) begin
                  addr_match <= 1'b1;
                  tx_req     <= sda_s;
                end else begin
                  state     <= WAIT_STOP;
                  bit_count <= '0;
                end
              end
            end else if (scl_fall && bit_count == 4'd8) begin
              sda_oe    <= 1'b1;
              bit_count <= '0;
              state     <= ADDR_ACK;
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              sda_oe    <= 1'b0;
              bit_count <= '0;
              if (!rw) begin
                state <= WR_DATA;
              end else if (tx_ready) begin
                shift_q <= usr.i_tx_data[6:0];
                sda_oe  <= ~usr.i_tx_data[7];
                state   <= RD_DATA;
              end
`ifdef I2C_SLAVE_CLK_STRETCH_EN
              else begin
                stretch <= 1'b1;
                scl_oe  <= 1'b1;
              end
`endif
            end
          end

          WR_DATA: begin
            if (scl_rise && bit_count < 4'd8) begin
              shift_q   <= {shift_q[5:0], sda_s};
              bit_count <= bit_count + 4'd1;
              if (bit_count == 4'd7) begin
                rx_data  <= {shift_q, sda_s};
                rx_valid <= 1'b1;
              end
            end else if (scl_fall && bit_count == 4'd8) begin
              sda_oe    <= 1'b1;
              bit_count <= '0;
              state     <= WR_ACK;
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              sda_oe    <= 1'b0;
              bit_count <= '0;
              state     <= WR_DATA;
            end
          end

          RD_DATA: begin
            // Bit 7 went out at the load edge; bits 6..0 follow, then the line is freed for the master's ACK.
            if (scl_fall) begin
              if (bit_count == 4'd7) begin
                sda_oe    <= 1'b0;
                bit_count <= '0;
                state     <= RD_ACK;
              end else begin
                sda_oe    <= ~shift_q[6];
                shift_q   <= {shift_q[5:0], 1'b0};
                bit_count <= bit_count + 4'd1;
              end
            end
          end

          RD_ACK: begin
            // A NACK leaves the state, so any falling edge seen here follows an ACK.
            if (scl_rise) begin
              if (sda_s) state  <= WAIT_STOP;
              else       tx_req <= 1'b1;
            end else if (scl_fall) begin
              bit_count <= '0;
              if (tx_ready) begin
                shift_q <= usr.i_tx_data[6:0];
                sda_oe  <= ~usr.i_tx_data[7];
                state   <= RD_DATA;
              end
`ifdef I2C_SLAVE_CLK_STRETCH_EN
              else begin
                stretch <= 1'b1;
                scl_oe  <= 1'b1;
              end
`endif
            end
          end

          WAIT_STOP: ;

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign usr.o_rx_data    = rx_data;
  assign usr.o_rx_valid   = rx_valid;
  assign usr.o_tx_req     = tx_req;
  assign usr.o_addr_match = addr_match;
  assign usr.o_rw         = rw;
  assign usr.o_busy       = busy;
  assign usr.o_state      = state;
  assign usr.o_bit_count  = bit_count;

endmodule

// File: tb/tb_i2c_slave_controller.sv
// Self-checking bench for i2c_slave_controller: a bit-banged I2C master with pull-ups,
// table-driven write/address-miss vectors plus read, repeated-START, reset and stretch sequences.
module tb_i2c_slave_controller;

  localparam int QTR = 10;  // i_clk cycles per quarter SCL period

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  wire  scl_bus;
  wire  sda_bus;

  pullup (scl_bus);
  pullup (sda_bus);
  assign scl_bus = m_scl ? 1'bz : 1'b0;
  assign sda_bus = m_sda ? 1'bz : 1'b0;

  i2c_slave_controller_if u_if ();

  i2c_slave_controller #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .io_scl  (scl_bus),
    .io_sda  (sda_bus),
    .usr     (u_if)
  );

  always #5 i_clk = ~i_clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Event monitors, sampled just after the active edge once the DUT has settled.
  int         rxv_cnt = 0, txr_cnt = 0, am_cnt = 0, drv_cnt = 0, busy_low_cnt = 0;
  int         stretch_run = 0, stretch_max = 0;
  logic [7:0] last_rx = 8'h00;

  always begin
    @(posedge i_clk);
    #2;
    if (u_if.o_rx_valid) begin
      rxv_cnt++;
      last_rx = u_if.o_rx_data;
    end
    if (u_if.o_tx_req)     txr_cnt++;
    if (u_if.o_addr_match) am_cnt++;
    if (sda_bus == 1'b0 && m_sda) drv_cnt++;
    if (!u_if.o_busy)      busy_low_cnt++;
    if (scl_bus == 1'b0 && m_scl) begin
      stretch_run++;
      if (stretch_run > stretch_max) stretch_max = stretch_run;
    end else begin
      stretch_run = 0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_q();
    repeat (QTR) @(negedge i_clk);
  endtask

  task automatic scl_high();
    int n = 0;
    m_scl = 1'b1;
    @(negedge i_clk);
    while (scl_bus !== 1'b1 && n < 1000) begin
      @(negedge i_clk);
      n++;
    end
    if (scl_bus !== 1'b1) check("scl_release_timeout", {31'b0, scl_bus}, 32'd1);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_q();
    scl_high();   wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    scl_high();   wait_q();
    m_sda = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    wait_q();
    scl_high();   wait_q(); wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_q();
    scl_high();   wait_q();
    b = sda_bus;  wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack);
  endtask

  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] data_byte;
    logic       exp_ack;         // bus level seen in both 9th clocks (0 = ACK)
    logic [3:0] exp_state_addr;  // state just after the address byte
    int         exp_rx_pulses;
    logic [7:0] exp_rx_data;
  } wr_vec_t;

  wr_vec_t vecs[6];

  initial begin
    logic       ack, ack2;
    logic [7:0] rd0, rd1;
    int         s_rxv, s_txr, s_am, s_drv, s_busy;

    vecs[0] = '{8'hA0, 8'h3C, 1'b0, 4'd3, 1, 8'h3C};
    vecs[1] = '{8'hA2, 8'h55, 1'b1, 4'd7, 0, 8'h3C};
    vecs[2] = '{8'hA0, 8'hFF, 1'b0, 4'd3, 1, 8'hFF};
    vecs[3] = '{8'h20, 8'h00, 1'b1, 4'd7, 0, 8'hFF};
    vecs[4] = '{8'hA0, 8'h00, 1'b0, 4'd3, 1, 8'h00};
    vecs[5] = '{8'hA0, 8'h81, 1'b0, 4'd3, 1, 8'h81};

    u_if.i_tx_data = 8'h00;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    u_if.i_tx_valid = 1'b1;
`endif

    // Reset state
    repeat (3) @(negedge i_clk);
    check("rst_state",      u_if.o_state, 4'd0);
    check("rst_busy",       u_if.o_busy, 1'b0);
    check("rst_rx_data",    u_if.o_rx_data, 8'h00);
    check("rst_pulses",     {u_if.o_rx_valid, u_if.o_tx_req, u_if.o_addr_match}, 3'b000);
    check("rst_rw",         u_if.o_rw, 1'b0);
    check("rst_bit_count",  u_if.o_bit_count, 4'd0);
    check("rst_lines",      {scl_bus, sda_bus}, 2'b11);
    i_reset = 1'b0;
    repeat (5) @(negedge i_clk);

    // Write and address-miss vectors
    for (int i = 0; i < 6; i++) begin
      s_rxv = rxv_cnt; s_am = am_cnt; s_drv = drv_cnt;
      i2c_start();
      check($sformatf("v%0d_busy_start", i), u_if.o_busy, 1'b1);
      write_byte(vecs[i].addr_byte, ack);
      check($sformatf("v%0d_addr_ack", i), ack, vecs[i].exp_ack);
      check($sformatf("v%0d_state_addr", i), u_if.o_state, vecs[i].exp_state_addr);
      write_byte(vecs[i].data_byte, ack2);
      check($sformatf("v%0d_data_ack", i), ack2, vecs[i].exp_ack);
      i2c_stop();
      check($sformatf("v%0d_rx_pulses", i), rxv_cnt - s_rxv, vecs[i].exp_rx_pulses);
      check($sformatf("v%0d_addr_match", i), am_cnt - s_am, vecs[i].exp_ack ? 0 : 1);
      check($sformatf("v%0d_rx_data", i), u_if.o_rx_data, vecs[i].exp_rx_data);
      check($sformatf("v%0d_sda_driven", i), (drv_cnt - s_drv) > 0, !vecs[i].exp_ack);
      check($sformatf("v%0d_end_state", i), {u_if.o_busy, u_if.o_state}, 5'd0);
    end
    check("rx_last_pulse_data", last_rx, 8'h81);

    // Read: 0x5A acknowledged, 0xC3 NACKed
    s_txr = txr_cnt; s_rxv = rxv_cnt;
    u_if.i_tx_data = 8'h5A;
    i2c_start();
    write_byte(8'hA1, ack);
    check("rd_addr_ack", ack, 1'b0);
    check("rd_rw", u_if.o_rw, 1'b1);
    u_if.i_tx_data = 8'hC3;
    read_byte(rd0, 1'b0);
    read_byte(rd1, 1'b1);
    check("rd_byte0", rd0, 8'h5A);
    check("rd_byte1", rd1, 8'hC3);
    check("rd_tx_req_pulses", txr_cnt - s_txr, 2);
    check("rd_state_after_nack", u_if.o_state, 4'd7);
    check("rd_sda_released", sda_bus, 1'b1);
    check("rd_no_rx_valid", rxv_cnt - s_rxv, 0);
    i2c_stop();
    check("rd_end_state", u_if.o_state, 4'd0);

    // Repeated START: write 0x11, Sr, read 0x77
    i2c_start();
    s_busy = busy_low_cnt;
    write_byte(8'hA0, ack);
    check("sr_wr_rw", u_if.o_rw, 1'b0);
    write_byte(8'h11, ack2);
    check("sr_wr_acks", {ack, ack2}, 2'b00);
    check("sr_rx_data", u_if.o_rx_data, 8'h11);
    u_if.i_tx_data = 8'h77;
    i2c_start();
    check("sr_state_after_sr", u_if.o_state, 4'd1);
    write_byte(8'hA1, ack);
    check("sr_rd_addr_ack", ack, 1'b0);
    check("sr_rd_rw", u_if.o_rw, 1'b1);
    read_byte(rd0, 1'b1);
    check("sr_rd_byte", rd0, 8'h77);
    check("sr_busy_held", busy_low_cnt - s_busy, 0);
    i2c_stop();
    check("sr_busy_end", u_if.o_busy, 1'b0);

    // Reset mid-write after 4 data bits of 0xF0
    i2c_start();
    write_byte(8'hA0, ack);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    check("mr_bit_count", u_if.o_bit_count, 4'd4);
    check("mr_state", u_if.o_state, 4'd3);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("mr_state_rst", u_if.o_state, 4'd0);
    check("mr_outputs_rst", {u_if.o_rx_data, u_if.o_busy, u_if.o_rw, u_if.o_bit_count}, 14'd0);
    check("mr_lines_rst", {m_scl ? scl_bus : 1'b1, sda_bus}, 2'b11);
    i_reset = 1'b0;
    i2c_stop();
    s_rxv = rxv_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h99, ack2);
    i2c_stop();
    check("mr_rewrite_acks", {ack, ack2}, 2'b00);
    check("mr_rewrite_data", u_if.o_rx_data, 8'h99);
    check("mr_rewrite_pulse", rxv_cnt - s_rxv, 1);

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    // Read with i_tx_valid held low while the target stretches SCL
    begin
      int rel;
      int n;
      u_if.i_tx_valid = 1'b0;
      u_if.i_tx_data  = 8'h5A;
      i2c_start();
      write_byte(8'hA1, ack);
      check("st_addr_ack", ack, 1'b0);
      fork
        read_byte(rd0, 1'b1);
        begin
          n = 0;
          while (!(scl_bus == 1'b0 && m_scl == 1'b1) && n < 500) begin
            @(negedge i_clk);
            n++;
          end
          repeat (20) @(negedge i_clk);
          u_if.i_tx_valid = 1'b1;
          rel = 0;
          do begin
            @(negedge i_clk);
            rel++;
          end while (scl_bus == 1'b0 && rel < 50);
          check("st_release_delay", rel, 2);
        end
      join
      check("st_byte", rd0, 8'h5A);
      check("st_held_20", stretch_max >= 20, 1'b1);
      check("st_state_nack", u_if.o_state, 4'd7);
      i2c_stop();
      check("st_end_state", u_if.o_state, 4'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
